// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_pkg : shared scheduler state encoding and UART parity constants
// Revision    : 1.0
// ----------------------------------------------------------------------------
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_e;

  localparam logic EVEN_PAR = 1'b0;
  localparam logic ODD_PAR  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_scheduler_if : requester handshake plus UART_TX control bundle
// Revision             : 1.0
// ----------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int IN_data = 8
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*IN_data-1:0] req_data;
  logic [NUM_REQ-1:0]         req_par_en;
  logic [NUM_REQ-1:0]         req_par_typ;
  logic                       tx_busy;
  logic                       Data_Valid;
  logic [IN_data-1:0]         P_DATA;
  logic                       PAR_EN;
  logic                       PAR_TYP;
  logic [IDW-1:0]             grant_id;
  logic                       active;
  logic                       err_timeout;

  // Scheduler side
  modport master (
    input  req_valid, req_data, req_par_en, req_par_typ, tx_busy,
    output req_ready, Data_Valid, P_DATA, PAR_EN, PAR_TYP,
           grant_id, active, err_timeout
  );

  // Requesters and serializer side
  modport slave (
    output req_valid, req_data, req_par_en, req_par_typ, tx_busy,
    input  req_ready, Data_Valid, P_DATA, PAR_EN, PAR_TYP,
           grant_id, active, err_timeout
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick starting after last_grant
// Revision   : 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               any
);

  logic [IDW-1:0] cand_id;

  // Walk the ring from last_grant+1; the first valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    any     = 1'b0;
    cand_id = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_id = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (!any && req[cand_id]) begin
        any          = 1'b1;
        gnt[cand_id] = 1'b1;
        gnt_id       = cand_id;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_scheduler : round-robin front end sharing one UART_TX serializer
// Revision          : 1.0
// ----------------------------------------------------------------------------
module uart_tx_scheduler
  import uart_tx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IN_data = 8,
  parameter int BUSY_TO = 4
) (
  input  logic                clk,
  input  logic                RST,
  uart_tx_scheduler_if.master bus
);

  localparam int               IDW      = $clog2(NUM_REQ);
  localparam int               CNT_W    = $clog2(BUSY_TO + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TO - 1);

  sched_state_e       state_q;
  logic [IDW-1:0]     last_grant_q;
  logic [IDW-1:0]     grant_id_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               data_valid_q;
  logic [IN_data-1:0] p_data_q;
  logic               par_en_q;
  logic               par_typ_q;
  logic               active_q;
  logic               err_timeout_q;

  logic [IN_data-1:0] p_data_d;
  logic               par_en_d;
  logic               par_typ_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .any        (gnt_any)
  );

  // One-hot payload select: each byte bit is an AND-OR across requesters.
  for (genvar b = 0; b < IN_data; b++) begin : g_bit
    logic [NUM_REQ-1:0] col;
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
      assign col[r] = bus.req_data[r*IN_data + b];
    end
    assign p_data_d[b] = |(col & gnt);
  end

  assign par_en_d  = |(bus.req_par_en  & gnt);
  assign par_typ_d = |(bus.req_par_typ & gnt);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      last_grant_q  <= IDW'(NUM_REQ - 1);
      grant_id_q    <= '0;
      cnt_q         <= '0;
      data_valid_q  <= 1'b0;
      p_data_q      <= '0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      active_q      <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      err_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            state_q      <= ISSUE;
            data_valid_q <= 1'b1;
            p_data_q     <= p_data_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            grant_id_q   <= gnt_id;
            last_grant_q <= gnt_id;
            active_q     <= 1'b1;
          end
        end
        ISSUE: begin
          state_q      <= WAIT_BUSY;
          data_valid_q <= 1'b0;
          cnt_q        <= '0;
        end
        WAIT_BUSY: begin
          // A serializer that never goes busy drops the byte; last_grant already moved on.
          if (bus.tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == CNT_LAST) begin
            state_q       <= IDLE;
            active_q      <= 1'b0;
            err_timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          data_valid_q <= 1'b0;
          active_q     <= 1'b0;
        end
      endcase
    end
  end

  // Ready is gated by reset so no requester sees a phantom accept while held in reset.
  assign bus.req_ready   = (RST && (state_q == IDLE)) ? gnt : '0;
  assign bus.Data_Valid  = data_valid_q;
  assign bus.P_DATA      = p_data_q;
  assign bus.PAR_EN      = par_en_q;
  assign bus.PAR_TYP     = par_typ_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.active      = active_q;
  assign bus.err_timeout = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_scheduler : scoreboard bench with requester and UART_TX models
// Revision             : 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_scheduler;
  import uart_tx_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int IN_data = 8;
  localparam int BUSY_TO = 4;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       pb;
  } exp_t;

  logic clk = 1'b0;
  logic RST = 1'b0;

  int   n_checks  = 0;
  int   n_errors  = 0;
  int   cyc       = 0;
  int   last_fall = -1;
  bit   chk_gap   = 1'b0;
  bit   uart_en   = 1'b1;
  int   pend [NUM_REQ];
  exp_t sb [$];

  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ), .IN_data(IN_data)) bus ();

  uart_tx_scheduler #(
    .NUM_REQ (NUM_REQ),
    .IN_data (IN_data),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus.master)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_frame(input int id, input logic [7:0] d, input logic pe,
                              input logic pt, input logic pb);
    exp_t e;
    e.id = id; e.data = d; e.pe = pe; e.pt = pt; e.pb = pb;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic pe,
                         input logic pt, input int n);
    bus.req_data[i*IN_data +: IN_data] = d;
    bus.req_par_en[i]  = pe;
    bus.req_par_typ[i] = pt;
    pend[i]            = n;
    bus.req_valid[i]   = 1'b1;
  endtask

  function automatic int pend_sum();
    int s = 0;
    foreach (pend[i]) s += pend[i];
    return s;
  endfunction

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit done = 1'b0;
    for (int n = 0; n < max_cyc && !done; n++) begin
      @(negedge clk);
      if (pend_sum() == 0 && !bus.active && !bus.tx_busy && sb.size() == 0) done = 1'b1;
    end
    check_eq("wait_idle", done, 1);
  endtask

  task automatic wait_busy(input int max_cyc);
    bit seen = 1'b0;
    for (int n = 0; n < max_cyc && !seen; n++) begin
      @(negedge clk);
      if (bus.tx_busy) seen = 1'b1;
    end
    check_eq("wait_busy", seen, 1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requesters: hold valid until accepted the requested number of times.
  initial begin : req_bfm
    logic [NUM_REQ-1:0] acc;
    forever begin
      @(negedge clk);
      acc = bus.req_ready & bus.req_valid;
      if (bus.req_ready != '0) check_eq("ready_onehot", $onehot(bus.req_ready), 1);
      @(posedge clk);
      #1;
      if (RST) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (acc[i]) begin
            check_eq("dv_after_grant", bus.Data_Valid, 1);
            check_eq("gid_after_grant", bus.grant_id, i);
            pend[i]--;
            if (pend[i] <= 0) bus.req_valid[i] = 1'b0;
          end
        end
      end
    end
  end

  // UART_TX model: busy from the cycle after Data_Valid for one cycle per line bit.
  initial begin : uart_model
    logic [7:0] d;
    logic       pe, pt, pbit;
    int         nb;
    bit         aborted;
    exp_t       e;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_en && RST && bus.Data_Valid) begin
        d    = bus.P_DATA;
        pe   = bus.PAR_EN;
        pt   = bus.PAR_TYP;
        pbit = pe ? (^d ^ pt) : 1'b1;
        if (chk_gap && last_fall >= 0) check_eq("b2b_gap", cyc - last_fall, 2);
        if (sb.size() == 0) begin
          check_eq("sb_unexpected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check_eq("grant_id", bus.grant_id, e.id);
          check_eq("p_data", d, e.data);
          check_eq("par_en", pe, e.pe);
          if (e.pe) begin
            check_eq("par_typ", pt, e.pt);
            check_eq("par_bit", pbit, e.pb);
          end
        end
        nb = pe ? 11 : 10;
        @(posedge clk);
        #1;
        bus.tx_busy = 1'b1;
        aborted     = 1'b0;
        for (int b = 0; b < nb && !aborted; b++) begin
          @(negedge clk);
          if (!RST) begin
            aborted = 1'b1;
          end else begin
            check_eq("p_stable", {bus.P_DATA, bus.PAR_EN, bus.PAR_TYP}, {d, pe, pt});
            check_eq("dv_in_busy", bus.Data_Valid, 0);
            @(posedge clk);
            #1;
          end
        end
        bus.tx_busy = 1'b0;
        if (!aborted) last_fall = cyc;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bus.req_valid   = '0;
    bus.req_data    = '0;
    bus.req_par_en  = '0;
    bus.req_par_typ = '0;
    foreach (pend[i]) pend[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dv",      bus.Data_Valid, 0);
    check_eq("rst_pdata",   bus.P_DATA, 0);
    check_eq("rst_par",     {bus.PAR_EN, bus.PAR_TYP}, 0);
    check_eq("rst_gid",     bus.grant_id, 0);
    check_eq("rst_active",  bus.active, 0);
    check_eq("rst_err",     bus.err_timeout, 0);
    check_eq("rst_ready",   bus.req_ready, 0);
    RST = 1'b1;

    // Round robin with all four continuously valid: 0,1,2,3,0
    expect_frame(0, 8'h10, 1'b0, EVEN_PAR, 1'b0);
    expect_frame(1, 8'h11, 1'b0, EVEN_PAR, 1'b0);
    expect_frame(2, 8'h12, 1'b0, EVEN_PAR, 1'b0);
    expect_frame(3, 8'h13, 1'b0, EVEN_PAR, 1'b0);
    expect_frame(0, 8'h10, 1'b0, EVEN_PAR, 1'b0);
    last_fall = -1;
    chk_gap   = 1'b1;
    sync();
    set_req(0, 8'h10, 1'b0, EVEN_PAR, 2);
    set_req(1, 8'h11, 1'b0, EVEN_PAR, 1);
    set_req(2, 8'h12, 1'b0, EVEN_PAR, 1);
    set_req(3, 8'h13, 1'b0, EVEN_PAR, 1);
    wait_idle(400);
    chk_gap = 1'b0;

    // Single request, no parity
    expect_frame(2, 8'h0A, 1'b0, EVEN_PAR, 1'b0);
    sync();
    set_req(2, 8'h0A, 1'b0, EVEN_PAR, 1);
    wait_idle(100);

    // Parity pass-through: even then odd, both parity bits 0
    expect_frame(1, 8'h09, 1'b1, EVEN_PAR, 1'b0);
    sync();
    set_req(1, 8'h09, 1'b1, EVEN_PAR, 1);
    wait_idle(100);
    expect_frame(1, 8'h08, 1'b1, ODD_PAR, 1'b0);
    sync();
    set_req(1, 8'h08, 1'b1, ODD_PAR, 1);
    wait_idle(100);

    // Data changes mid-frame must not reach the serializer
    expect_frame(0, 8'h07, 1'b0, EVEN_PAR, 1'b0);
    sync();
    set_req(0, 8'h07, 1'b0, EVEN_PAR, 1);
    wait_busy(20);
    bus.req_data[7:0] = 8'hFC;
    wait_idle(100);

    // Timeout: serializer never goes busy
    uart_en = 1'b0;
    sync();
    set_req(3, 8'h5A, 1'b0, EVEN_PAR, 1);
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
        @(negedge clk);
        if (bus.req_ready[3]) seen = 1'b1;
      end
      check_eq("to_grant_seen", seen, 1);
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check_eq($sformatf("err_timeout_c%0d", k), bus.err_timeout, (k == 6));
      if (k == 3) check_eq("to_active_wait", bus.active, 1);
      if (k == 6) check_eq("to_active_idle", bus.active, 0);
    end
    uart_en = 1'b1;
    expect_frame(0, 8'h20, 1'b0, EVEN_PAR, 1'b0);
    expect_frame(3, 8'h23, 1'b0, EVEN_PAR, 1'b0);
    sync();
    set_req(3, 8'h23, 1'b0, EVEN_PAR, 1);
    set_req(0, 8'h20, 1'b0, EVEN_PAR, 1);
    wait_idle(200);

    // Reset during WAIT_DONE
    expect_frame(0, 8'h31, 1'b1, ODD_PAR, 1'b0);
    sync();
    set_req(0, 8'h31, 1'b1, ODD_PAR, 1);
    wait_busy(20);
    repeat (2) @(negedge clk);
    sync();
    RST = 1'b0;
    #1;
    check_eq("mrst_dv",     bus.Data_Valid, 0);
    check_eq("mrst_pdata",  bus.P_DATA, 0);
    check_eq("mrst_par",    {bus.PAR_EN, bus.PAR_TYP}, 0);
    check_eq("mrst_gid",    bus.grant_id, 0);
    check_eq("mrst_active", bus.active, 0);
    check_eq("mrst_err",    bus.err_timeout, 0);
    expect_frame(0, 8'h40, 1'b0, EVEN_PAR, 1'b0);
    expect_frame(1, 8'h41, 1'b0, EVEN_PAR, 1'b0);
    set_req(1, 8'h41, 1'b0, EVEN_PAR, 1);
    set_req(0, 8'h40, 1'b0, EVEN_PAR, 1);
    #1;
    check_eq("mrst_ready", bus.req_ready, 0);
    repeat (2) @(posedge clk);
    #3;
    RST = 1'b1;
    wait_idle(300);

    check_eq("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
